// File: rtl/uart_prog_loader_pkg.sv
// loader_pkg: shared state encodings and constants for the UART program loader.
// Rev 1.0
`default_nettype none

package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    L_HDR  = 2'd0,
    L_WORD = 2'd1,
    L_DONE = 2'd2
  } ld_state_t;

  localparam int HDR_ZERO_WORDS = 256;

endpackage

`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: serial input and instruction-memory write port of the loader.
// Rev 1.0
`default_nettype none

interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rxd;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              loading;
  logic              done;

  modport master (
    input  rxd,
    output rx_data, rx_valid, frame_err, ld_we, ld_addr, ld_wdata, loading, done
  );

  modport slave (
    output rxd,
    input  rx_data, rx_valid, frame_err, ld_we, ld_addr, ld_wdata, loading, done
  );
endinterface

`default_nettype wire

// File: rtl/uart_prog_loader_rx.sv
// uart_rx_core: 8N1 UART receiver with a 2-flop input synchroniser.
// Rev 1.0
`default_nettype none

module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  rx_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Mid-start-bit recheck rejects short glitches without any pulse.
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (sync2_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART boot loader writing little-endian words into instruction memory.
// Rev 1.0
`default_nettype none

module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_prog_loader_if.master   lb
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rxd_i       (lb.rxd),
    .rx_data_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err)
  );

  ld_state_t         state_q;
  logic [8:0]        total_q;
  logic [8:0]        written_q;
  logic [1:0]        lane_q;
  logic [31:0]       word_q;
  logic              ld_we_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_wdata_q;
  logic              loading_q;
  logic              done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= L_HDR;
      total_q    <= '0;
      written_q  <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      ld_we_q    <= 1'b0;
      ld_addr_q  <= '0;
      ld_wdata_q <= '0;
      loading_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      ld_we_q <= 1'b0;
      case (state_q)
        L_HDR: begin
          if (rx_valid) begin
            total_q   <= (rx_byte == 8'd0) ? 9'(HDR_ZERO_WORDS) : {1'b0, rx_byte};
            written_q <= '0;
            lane_q    <= '0;
            ld_addr_q <= '0;
            state_q   <= L_WORD;
          end
        end
        L_WORD: begin
          if (rx_valid) begin
            lane_q <= lane_q + 2'd1;
            word_q[{lane_q, 3'b000} +: 8] <= rx_byte;
            if (lane_q == 2'd3) begin
              ld_wdata_q <= {rx_byte, word_q[23:0]};
              ld_we_q    <= 1'b1;
            end
          end
          // Address wraps naturally at 2^ADDR_W; the word count is tracked separately.
          if (ld_we_q) begin
            ld_addr_q <= ld_addr_q + 1'b1;
            written_q <= written_q + 9'd1;
            if (written_q + 9'd1 == total_q) begin
              state_q   <= L_DONE;
              loading_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        L_DONE: ;
        default: state_q <= L_HDR;
      endcase
    end
  end

  assign lb.rx_data   = rx_byte;
  assign lb.rx_valid  = rx_valid;
  assign lb.frame_err = frame_err;
  assign lb.ld_we     = ld_we_q;
  assign lb.ld_addr   = ld_addr_q;
  assign lb.ld_wdata  = ld_wdata_q;
  assign lb.loading   = loading_q;
  assign lb.done      = done_q;

endmodule

`default_nettype wire
